// File: rtl/io_interrupt_ctrl.sv
// io_interrupt_ctrl: INPR/OUTR, FGI/FGO, IEN and R flip-flop with I/O handshakes for the basic computer
module io_interrupt_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_inp,
   input  logic       cpu_out,
   input  logic       cpu_ski,
   input  logic       cpu_sko,
   input  logic       cpu_ion,
   input  logic       cpu_iof,
   input  logic [7:0] ac_low,
   input  logic       instr_done,
   input  logic       int_ack,
   output logic [7:0] inpr,
   output logic       skip,
   output logic       int_cycle,
   output logic       fgi,
   output logic       fgo,
   output logic       ien,
   output logic       ovr_err,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready
);
   logic [7:0] outr;
   assign in_ready  = ~fgi;
   assign out_valid = ~fgo;
   assign out_data  = outr;
   // skip request uses the current registered flags in the strobe cycle
   always_comb skip = (cpu_ski & fgi) | (cpu_sko & fgo);
   // input side: source handshake fills INPR, INP hands it to AC
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         inpr <= 8'h00;
         fgi  <= 1'b0;
      end else if (in_valid & ~fgi) begin
         inpr <= in_data;
         fgi  <= 1'b1;
      end else if (cpu_inp)
         fgi <= 1'b0;
   // output side: OUT loads OUTR only when the sink has drained the previous byte
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         outr    <= 8'h00;
         fgo     <= 1'b1;
         ovr_err <= 1'b0;
      end else begin
         if (cpu_out & fgo) begin
            outr <= ac_low;
            fgo  <= 1'b0;
         end else if (~fgo & out_ready)
            fgo <= 1'b1;
         if (cpu_out & ~fgo)
            ovr_err <= 1'b1;
      end
   // interrupt enable and R flip-flop; acknowledge clears both and wins over any set
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ien       <= 1'b0;
         int_cycle <= 1'b0;
      end else begin
         ien       <= int_ack ? 1'b0 : cpu_iof ? 1'b0 : cpu_ion ? 1'b1 : ien;
         int_cycle <= int_ack ? 1'b0 : (instr_done & ien & (fgi | fgo)) ? 1'b1 : int_cycle;
      end
endmodule

// File: tb/tb_io_interrupt_ctrl.sv
// tb_io_interrupt_ctrl: scoreboard bench for the I/O and interrupt controller
module tb_io_interrupt_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       cpu_inp = 0, cpu_out = 0, cpu_ski = 0, cpu_sko = 0, cpu_ion = 0, cpu_iof = 0;
   logic [7:0] ac_low = 0, in_data = 0;
   logic       instr_done = 0, int_ack = 0, in_valid = 0, out_ready = 0;
   logic [7:0] inpr, out_data;
   logic       skip, int_cycle, fgi, fgo, ien, ovr_err, in_ready, out_valid;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   int         errors = 0, checks = 0;

   io_interrupt_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cpu_inp(cpu_inp), .cpu_out(cpu_out), .cpu_ski(cpu_ski),
      .cpu_sko(cpu_sko), .cpu_ion(cpu_ion), .cpu_iof(cpu_iof), .ac_low(ac_low),
      .instr_done(instr_done), .int_ack(int_ack), .inpr(inpr), .skip(skip),
      .int_cycle(int_cycle), .fgi(fgi), .fgo(fgo), .ien(ien), .ovr_err(ovr_err),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({fgi, fgo, ien, int_cycle, in_ready, out_valid, ovr_err} !== 7'b0100100) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0100100", {fgi, fgo, ien, int_cycle, in_ready, out_valid, ovr_err});
      end
      checks++;
      if (inpr !== 8'h00 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: inpr=%h out_data=%h want 00 00", inpr, out_data);
      end
   endtask

   task automatic test_input_poll();
      cpu_ski = 1'b1;
      #1;
      checks++;
      if (skip !== 1'b0) begin errors++; $display("FAIL ski_empty: skip=%b want 0", skip); end
      cpu_ski = 1'b0;
      in_data = 8'hA5;
      in_valid = 1'b1;
      exp_q.push_back(8'hA5);
      step();
      in_valid = 1'b0;
      in_data = 8'h11;
      checks++;
      if (fgi !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL in_accept: fgi=%b in_ready=%b want 1 0", fgi, in_ready);
      end
      cpu_ski = 1'b1;
      #1;
      checks++;
      if (skip !== 1'b1) begin errors++; $display("FAIL ski_full: skip=%b want 1", skip); end
      step();
      cpu_ski = 1'b0;
      cpu_inp = 1'b1;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL inp_data: scoreboard empty, got %h", inpr);
      end else begin
         exp_b = exp_q.pop_front();
         if (inpr !== exp_b) begin errors++; $display("FAIL inp_data: inpr=%h want %h", inpr, exp_b); end
      end
      step();
      cpu_inp = 1'b0;
      checks++;
      if (fgi !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL inp_clear: fgi=%b in_ready=%b want 0 1", fgi, in_ready);
      end
      cpu_inp = 1'b1;
      step();
      cpu_inp = 1'b0;
      checks++;
      if (inpr !== 8'hA5 || fgi !== 1'b0 || ovr_err !== 1'b0) begin
         errors++;
         $display("FAIL inp_stale: inpr=%h fgi=%b ovr=%b want a5 0 0", inpr, fgi, ovr_err);
      end
   endtask

   task automatic test_output();
      ac_low = 8'h3C;
      cpu_out = 1'b1;
      exp_q.push_back(8'h3C);
      step();
      cpu_out = 1'b0;
      ac_low = 8'h00;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
         errors++;
         $display("FAIL out_load: valid=%b data=%h want 1 3c", out_valid, out_data);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            errors++;
            $display("FAIL out_hold%0d: valid=%b data=%h want 1 3c", i, out_valid, out_data);
         end
      end
      ac_low = 8'h55;
      cpu_out = 1'b1;
      step();
      cpu_out = 1'b0;
      checks++;
      if (ovr_err !== 1'b1 || out_data !== 8'h3C || fgo !== 1'b0) begin
         errors++;
         $display("FAIL out_overrun: ovr=%b data=%h fgo=%b want 1 3c 0", ovr_err, out_data, fgo);
      end
      cpu_sko = 1'b1;
      #1;
      checks++;
      if (skip !== 1'b0) begin errors++; $display("FAIL sko_busy: skip=%b want 0", skip); end
      cpu_sko = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (!(out_valid && out_ready) || exp_q.size() == 0) begin
         errors++;
         $display("FAIL out_drain: valid=%b pending=%0d want handshake", out_valid, exp_q.size());
      end else begin
         exp_b = exp_q.pop_front();
         if (out_data !== exp_b) begin errors++; $display("FAIL out_drain: data=%h want %h", out_data, exp_b); end
      end
      step();
      out_ready = 1'b0;
      checks++;
      if (fgo !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL out_done: fgo=%b valid=%b want 1 0", fgo, out_valid);
      end
      cpu_sko = 1'b1;
      #1;
      checks++;
      if (skip !== 1'b1) begin errors++; $display("FAIL sko_idle: skip=%b want 1", skip); end
      cpu_sko = 1'b0;
   endtask

   task automatic test_interrupt();
      cpu_ion = 1'b1;
      step();
      cpu_ion = 1'b0;
      checks++;
      if (ien !== 1'b1) begin errors++; $display("FAIL ion: ien=%b want 1", ien); end
      in_data = 8'h5A;
      in_valid = 1'b1;
      exp_q.push_back(8'h5A);
      step();
      in_valid = 1'b0;
      checks++;
      if (int_cycle !== 1'b0 || fgi !== 1'b1) begin
         errors++;
         $display("FAIL int_wait: int_cycle=%b fgi=%b want 0 1", int_cycle, fgi);
      end
      instr_done = 1'b1;
      step();
      instr_done = 1'b0;
      checks++;
      if (int_cycle !== 1'b1) begin errors++; $display("FAIL int_enter: int_cycle=%b want 1", int_cycle); end
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      checks++;
      if (int_cycle !== 1'b0 || ien !== 1'b0) begin
         errors++;
         $display("FAIL int_ack: int_cycle=%b ien=%b want 0 0", int_cycle, ien);
      end
      instr_done = 1'b1;
      step();
      instr_done = 1'b0;
      checks++;
      if (int_cycle !== 1'b0) begin errors++; $display("FAIL int_disabled: int_cycle=%b want 0", int_cycle); end
      cpu_inp = 1'b1;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL int_inp: scoreboard empty, got %h", inpr);
      end else begin
         exp_b = exp_q.pop_front();
         if (inpr !== exp_b) begin errors++; $display("FAIL int_inp: inpr=%h want %h", inpr, exp_b); end
      end
      step();
      cpu_inp = 1'b0;
      cpu_ion = 1'b1;
      step();
      cpu_ion = 1'b0;
      instr_done = 1'b1;
      int_ack = 1'b1;
      step();
      instr_done = 1'b0;
      int_ack = 1'b0;
      checks++;
      if (int_cycle !== 1'b0 || ien !== 1'b0) begin
         errors++;
         $display("FAIL ack_vs_set: int_cycle=%b ien=%b want 0 0", int_cycle, ien);
      end
   endtask

   task automatic test_same_cycle();
      cpu_ion = 1'b1;
      instr_done = 1'b1;
      step();
      cpu_ion = 1'b0;
      instr_done = 1'b0;
      checks++;
      if (int_cycle !== 1'b0 || ien !== 1'b1) begin
         errors++;
         $display("FAIL ion_with_done: int_cycle=%b ien=%b want 0 1", int_cycle, ien);
      end
      instr_done = 1'b1;
      step();
      instr_done = 1'b0;
      checks++;
      if (int_cycle !== 1'b1) begin errors++; $display("FAIL next_done: int_cycle=%b want 1", int_cycle); end
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      cpu_ion = 1'b1;
      cpu_iof = 1'b1;
      step();
      cpu_ion = 1'b0;
      cpu_iof = 1'b0;
      checks++;
      if (ien !== 1'b0) begin errors++; $display("FAIL ion_iof: ien=%b want 0", ien); end
      cpu_ion = 1'b1;
      step();
      cpu_ion = 1'b0;
      cpu_iof = 1'b1;
      step();
      cpu_iof = 1'b0;
      checks++;
      if (ien !== 1'b0) begin errors++; $display("FAIL iof: ien=%b want 0", ien); end
   endtask

   task automatic test_async_reset();
      cpu_ion = 1'b1;
      step();
      cpu_ion = 1'b0;
      instr_done = 1'b1;
      step();
      instr_done = 1'b0;
      ac_low = 8'h99;
      cpu_out = 1'b1;
      exp_q.push_back(8'h99);
      in_data = 8'h77;
      in_valid = 1'b1;
      step();
      cpu_out = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (int_cycle !== 1'b1 || out_valid !== 1'b1 || fgi !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: int_cycle=%b valid=%b fgi=%b want 1 1 1", int_cycle, out_valid, fgi);
      end
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if ({fgi, fgo, ien, int_cycle, in_ready, out_valid, ovr_err} !== 7'b0100100) begin
         errors++;
         $display("FAIL async_flags: got %b want 0100100", {fgi, fgo, ien, int_cycle, in_ready, out_valid, ovr_err});
      end
      checks++;
      if (inpr !== 8'h00 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL async_data: inpr=%h out_data=%h want 00 00", inpr, out_data);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_input_poll();
      test_output();
      test_interrupt();
      test_same_cycle();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/io_interrupt_ctrl.md
# io_interrupt_ctrl

Input/output and interrupt controller for the basic computer. Sits beside the control unit, and owns the input register (INPR), output register (OUTR), the FGI/FGO flags, the IEN interrupt enable and the R interrupt-cycle flip-flop. It executes the six register-reference I/O instructions (INP, OUT, SKI, SKO, ION, IOF) on strobes from the control logic. It also runs valid/ready handshakes to an external keyboard-side source and printer-side sink, and decides at each instruction boundary whether the next cycle group is an interrupt cycle.

## Interface

- No parameters; data width fixed at 8 bits (AC[7:0] ↔ INPR/OUTR).

- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_inp / cpu_out / cpu_ski / cpu_sko / cpu_ion / cpu_iof  in  1 each  one-cycle instruction strobes (D7·I·T3 decode)
- ac_low  in  8  AC[7:0], sampled on cpu_out
- instr_done  in  1  one-cycle pulse in the cycle the sequence counter clears (end of any instruction)
- int_ack  in  1  one-cycle pulse at R·T2 (interrupt cycle complete)
- inpr  out  8  INPR contents to AC[7:0]; AC loads on cpu_inp
- skip  out  1  combinational PC-increment request
- int_cycle  out  1  R flip-flop; control unit runs R·T0..T2 while high
- fgi, fgo, ien  out  1 each  flag state (observability)
- ovr_err  out  1  sticky: OUT issued while FGO=0
- in_data  in  8  input byte from source
- in_valid  in  1  source has a byte
- in_ready  out  1  = ~fgi
- out_data  out  8  = OUTR
- out_valid  out  1  = ~fgo
- out_ready  in  1  sink accepts byte

## Operation

- Reset values: INPR=0, OUTR=0, FGI=0, FGO=1, IEN=0, R=0, ovr_err=0. Therefore in_ready=1 and out_valid=0.
- Input transfer: in_valid & in_ready on an edge → INPR←in_data, FGI←1.
- cpu_inp → FGI←0. INPR unchanged. With FGI=0 the stale INPR is delivered, with no error.
- Output transfer: out_valid & out_ready on an edge → FGO←1.
  - OUTR is held stable while out_valid=1.
- cpu_out with FGO=1 → OUTR←ac_low, FGO←0.
- cpu_out with FGO=0 → OUTR unchanged, FGO unchanged, ovr_err←1.
- skip = (cpu_ski & fgi) | (cpu_sko & fgo), same cycle, using current registered flags.
- IEN:
  - int_ack clears IEN. This has the highest priority.
  - Otherwise cpu_iof clears IEN.
  - Otherwise cpu_ion sets IEN.
- R:
  - Set on an edge where instr_done & ien & (fgi | fgo) & ~R. Uses pre-edge flag values.
  - Cleared on int_ack. If int_ack and the set condition coincide, clear wins.
- Flag priority in a single cycle:
  - cpu_inp clear and an input acceptance cannot coincide, because acceptance requires FGI=0.
  - If FGO=1 and cpu_out arrive in the same cycle, cpu_out wins.
  - out_ready is ignored while out_valid=0.
- Reset asserted mid-transfer aborts it: flags return to reset values, and any pending int_cycle is dropped.

## Timing

- Every register update occurs on the rising clk edge. The only combinational output is skip; in_ready, out_valid and out_data are direct functions of registers.
- Latency from input byte to interrupt visibility:
  - Acceptance edge N → FGI=1 after edge N.
  - R rises at the first edge with instr_done=1 after that, if IEN=1.
- ION enables interrupts after its edge. An instr_done in the same cycle as cpu_ion samples the old IEN=0, so R is not set until the following instruction boundary.
- int_ack edge: R→0 and IEN→0 simultaneously; int_cycle falls the next cycle.
- Throughput: at most one byte per direction per CPU handshake. A new byte needs cpu_inp/cpu_out between transfers.

## Test plan

- Reset release: fgi=0, fgo=1, ien=0, int_cycle=0, in_ready=1, out_valid=0, inpr=0x00.
- Input with polling:
  - in_data=0xA5 with in_valid for one cycle → fgi=1, in_ready=0.
  - cpu_ski → skip=1 in the same cycle.
  - cpu_inp → inpr=0xA5, and fgi=0 the next cycle.
- Output:
  - ac_low=0x3C with cpu_out → out_valid=1, out_data=0x3C.
  - out_ready held low for 5 cycles → data stable.
  - out_ready pulse → fgo=1.
  - A second cpu_out while fgo=0 → ovr_err=1, out_data stays 0x3C.
- Interrupt entry:
  - cpu_ion, then fgi←1 via transfer, then instr_done → int_cycle=1.
  - int_ack → int_cycle=0, ien=0.
  - A further instr_done with fgi=1 → int_cycle stays 0.
- Same-cycle events:
  - cpu_ion with instr_done, fgo=1 → no R. The next instr_done → R=1.
  - cpu_ion and cpu_iof together → ien=0.
- Async reset mid-interrupt: assert rst_n low with int_cycle=1 and OUT pending → all outputs at reset values immediately, without a clock edge.
